// File: rtl/traffic_pkg.sv
// Shared phase codes and lamp encoding for the traffic sequencer and its display/decoder blocks.
package traffic_pkg;

    typedef enum logic [2:0] {
        MG    = 3'd0,
        MY    = 3'd1,
        CG    = 3'd2,
        CY    = 3'd3,
        FLASH = 3'd4
    } phase_t;

    // Lamp buses are {R,Y,G}
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Timing-tick divider: one-clk enable pulse every CLK_DIV clks, keeping the sequencer in the clk domain.
module tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic-light sequencer: side-road demand latch, tick-gated phase FSM,
// registered lamp and countdown outputs, night flashing-yellow mode.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_DIV    = 50_000_000,
    parameter int MIN_GREEN  = 10,
    parameter int MAX_GREEN  = 60,
    parameter int SIDE_GREEN = 15,
    parameter int YELLOW     = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             side_req,
    input  logic             night_mode,
    output logic [2:0]       m_light,
    output logic [2:0]       c_light,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remain
);

    localparam logic [CNT_W-1:0] D_MIN  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] D_MAX  = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] D_SIDE = CNT_W'(SIDE_GREEN);
    localparam logic [CNT_W-1:0] D_YEL  = CNT_W'(YELLOW);

    logic             tick;
    phase_t           state, state_nxt;
    logic [CNT_W-1:0] elapsed, elapsed_nxt, e1;
    logic             blink, blink_nxt;
    logic             req_pend, req_nxt, enter_cg;
    logic [2:0]       m_nxt, c_nxt;
    logic [CNT_W-1:0] remain_nxt;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign phase = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MG;
            elapsed  <= '0;
            blink    <= 1'b0;
            req_pend <= 1'b0;
            m_light  <= LAMP_G;
            c_light  <= LAMP_R;
            remain   <= D_MAX;
        end else begin
            state    <= state_nxt;
            elapsed  <= elapsed_nxt;
            blink    <= blink_nxt;
            req_pend <= req_nxt;
            m_light  <= m_nxt;
            c_light  <= c_nxt;
            remain   <= remain_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        elapsed_nxt = elapsed;
        blink_nxt   = blink;
        enter_cg    = 1'b0;
        e1          = elapsed + CNT_W'(1);

        case (state)
            MG: if (tick) begin
                if ((e1 >= D_MIN && (req_pend || night_mode)) || e1 == D_MAX) begin
                    state_nxt   = MY;
                    elapsed_nxt = '0;
                end else begin
                    elapsed_nxt = e1;
                end
            end
            MY: if (tick) begin
                if (e1 == D_YEL) begin
                    elapsed_nxt = '0;
                    if (night_mode) begin
                        state_nxt = FLASH;
                        blink_nxt = 1'b1;
                    end else begin
                        state_nxt = CG;
                        enter_cg  = 1'b1;
                    end
                end else begin
                    elapsed_nxt = e1;
                end
            end
            CG: if (tick) begin
                if (e1 == D_SIDE) begin
                    state_nxt   = CY;
                    elapsed_nxt = '0;
                end else begin
                    elapsed_nxt = e1;
                end
            end
            CY: if (tick) begin
                if (e1 == D_YEL) begin
                    state_nxt   = MG;
                    elapsed_nxt = '0;
                end else begin
                    elapsed_nxt = e1;
                end
            end
            FLASH: if (tick) begin
                if (!night_mode) begin
                    state_nxt   = MG;
                    elapsed_nxt = '0;
                    blink_nxt   = 1'b0;
                end else begin
                    blink_nxt = ~blink;
                end
            end
            // Unused codes recover immediately, without waiting for a tick
            default: begin
                state_nxt   = MG;
                elapsed_nxt = '0;
                blink_nxt   = 1'b0;
            end
        endcase

        // A sensor hit on the CG-entry clk must survive the clear
        req_nxt = side_req | (req_pend & ~enter_cg);

        m_nxt      = LAMP_G;
        c_nxt      = LAMP_R;
        remain_nxt = D_MAX - elapsed_nxt;
        case (state_nxt)
            MY: begin
                m_nxt      = LAMP_Y;
                remain_nxt = D_YEL - elapsed_nxt;
            end
            CG: begin
                m_nxt      = LAMP_R;
                c_nxt      = LAMP_G;
                remain_nxt = D_SIDE - elapsed_nxt;
            end
            CY: begin
                m_nxt      = LAMP_R;
                c_nxt      = LAMP_Y;
                remain_nxt = D_YEL - elapsed_nxt;
            end
            FLASH: begin
                m_nxt      = blink_nxt ? LAMP_Y : LAMP_OFF;
                c_nxt      = blink_nxt ? LAMP_Y : LAMP_OFF;
                remain_nxt = '0;
            end
            default: ;
        endcase
    end

endmodule
